// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the register/ALU/RAM datapath
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_wait,
  output logic             ir_we,
  output logic [3:0]       opcode,
  output logic             ALUsrc,
  output logic             RegWrite,
  output logic             MemRW,
  output logic             MemtoReg,
  output logic             PCsrc,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [2:0] F3_BNE = 3'b001;

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic        illegal_q;
  logic        set_illegal;

  logic [6:0]  major;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        is_r, is_i, is_load, is_store, is_branch, is_halt, is_illegal;
  logic [3:0]  alu_sel;
  logic        imm_sel;
  logic        unused_ir;

  assign major    = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7_5 = ir_q[30];

  // Register indices and immediates belong to the datapath; only the control fields are decoded here.
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  assign is_r       = (major == OP_R);
  assign is_i       = (major == OP_I);
  assign is_load    = (major == OP_LOAD);
  assign is_store   = (major == OP_STORE);
  assign is_branch  = (major == OP_BRANCH);
  assign is_halt    = (major == OP_HALT);
  assign is_illegal = !(is_r || is_i || is_load || is_store || is_branch || is_halt);
  assign imm_sel    = is_i || is_load || is_store;

  always_comb begin
    alu_sel = ALU_ADD;
    if (is_branch) begin
      alu_sel = ALU_SUB;
    end else if (is_r || is_i) begin
      unique case (funct3)
        3'b000:  alu_sel = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_sel = ALU_AND;
        3'b110:  alu_sel = ALU_OR;
        3'b100:  alu_sel = ALU_XOR;
        3'b001:  alu_sel = ALU_SLL;
        3'b101:  alu_sel = ALU_SRL;
        3'b010:  alu_sel = ALU_SLT;
        default: alu_sel = ALU_ADD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q <= 32'h0;
    end else if (ir_we) begin
      ir_q <= instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else if (set_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  // Every instruction asserts pc_we on exactly its final cycle, so that strobe doubles as the retire event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (pc_we) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    ir_we       = 1'b0;
    opcode      = 4'b0000;
    ALUsrc      = 1'b0;
    RegWrite    = 1'b0;
    MemRW       = 1'b0;
    MemtoReg    = 1'b0;
    PCsrc       = 1'b0;
    pc_we       = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // Gating with reset keeps every output low while reset is held.
        if (run && reset) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_illegal) begin
          set_illegal = 1'b1;
          state_d     = S_HALT;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        opcode = alu_sel;
        ALUsrc = imm_sel;
        if (is_branch) begin
          pc_we   = 1'b1;
          PCsrc   = (funct3 == F3_BNE) ? !zero : zero;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        opcode = alu_sel;
        ALUsrc = imm_sel;
        MemRW  = is_store;
        if (!mem_wait) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = is_load;
        pc_we    = 1'b1;
        state_d  = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven and randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int CNT_W = 4;
  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             run = 1'b0;
  logic [31:0]      instr = 32'h0;
  logic             zero = 1'b0;
  logic             mem_wait = 1'b0;
  logic             ir_we;
  logic [3:0]       opcode;
  logic             ALUsrc;
  logic             RegWrite;
  logic             MemRW;
  logic             MemtoReg;
  logic             PCsrc;
  logic             pc_we;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  int errors = 0;
  int checks = 0;
  int cnt_model = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .zero(zero),
    .mem_wait(mem_wait), .ir_we(ir_we), .opcode(opcode), .ALUsrc(ALUsrc),
    .RegWrite(RegWrite), .MemRW(MemRW), .MemtoReg(MemtoReg), .PCsrc(PCsrc),
    .pc_we(pc_we), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  // One instruction: stimulus plus the expected end-to-end behaviour.
  typedef struct {
    logic [31:0] instr;
    bit          zero;
    int          waits;
    int          lat;
    logic [3:0]  op;
    bit          alusrc, regw, m2r, ld, st, pcsrc, ill, hlt;
  } vec_t;

  function automatic logic [3:0] alu_of(logic [2:0] f3, bit sub);
    case (f3)
      3'b000:  return sub ? 4'd1 : 4'd0;
      3'b111:  return 4'd2;
      3'b110:  return 4'd3;
      3'b100:  return 4'd4;
      3'b001:  return 4'd5;
      3'b101:  return 4'd6;
      3'b010:  return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic vec_t model(logic [31:0] i, bit z, int w);
    vec_t v;
    v = '{default: 0};
    v.instr = i;
    v.zero  = z;
    case (i[6:0])
      7'b0110011: begin v.lat = 4; v.regw = Y; v.op = alu_of(i[14:12], i[30]); end
      7'b0010011: begin v.lat = 4; v.regw = Y; v.alusrc = Y; v.op = alu_of(i[14:12], N); end
      7'b0000011: begin v.ld = Y; v.waits = w; v.lat = 5 + w; v.regw = Y; v.m2r = Y; v.alusrc = Y; end
      7'b0100011: begin v.st = Y; v.waits = w; v.lat = 4 + w; v.alusrc = Y; end
      7'b1100011: begin v.lat = 3; v.op = 4'd1; v.pcsrc = (i[14:12] == 3'b001) ? !z : z; end
      7'b1111111: v.hlt = Y;
      default:    begin v.hlt = Y; v.ill = Y; end
    endcase
    return v;
  endfunction

  // Output vector {ir_we, opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_we, halted, illegal}
  // expected in cycle k of an instruction, cycle 1 being its FETCH cycle.
  function automatic logic [12:0] expect_cycle(vec_t v, int k);
    bit alu, last, memph;
    if (v.hlt) return {k == 1, 4'h0, 6'b0, k >= 3, v.ill && (k >= 3)};
    memph = (v.ld || v.st) && (k >= 4) && (k <= 4 + v.waits);
    alu   = (k == 3) || memph;
    last  = (k == v.lat);
    return {k == 1, alu ? v.op : 4'h0, alu && v.alusrc, last && v.regw, memph && v.st,
            last && v.m2r, last && v.pcsrc, last, 1'b0, 1'b0};
  endfunction

  function automatic logic [12:0] observed();
    return {ir_we, opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_we, halted, illegal};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset    = 1'b0;
    run      = 1'b1;
    mem_wait = 1'($urandom_range(0, 1));
    #1;
    chk("reset outputs", 32'(observed()), 32'h0);
    chk("reset count", 32'(instr_count), 32'h0);
    @(negedge clk);
    reset     = 1'b1;
    run       = 1'b0;
    cnt_model = 0;
  endtask

  task automatic run_vec(vec_t v, string tag);
    int limit;
    limit = v.hlt ? 22 : v.lat;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      instr = (k == 1) ? v.instr : $urandom;
      run   = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      zero  = (k == 3) ? v.zero : 1'($urandom_range(0, 1));
      if (k >= 4 && k < 4 + v.waits) mem_wait = 1'b1;
      else if ((v.ld || v.st) && k == 4 + v.waits) mem_wait = 1'b0;
      else mem_wait = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("%s %h cyc%0d", tag, v.instr, k), 32'(observed()), 32'(expect_cycle(v, k)));
    end
    if (v.hlt) begin
      reset_dut();
    end else begin
      @(posedge clk);
      #1;
      cnt_model = (cnt_model + 1) % (1 << CNT_W);
      chk($sformatf("%s %h count", tag, v.instr), 32'(instr_count), 32'(cnt_model));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[16];
    logic [31:0] r;
    int          c;

    tbl[0]  = '{32'h002081B3, N, 0, 4, 4'h0, N, Y, N, N, N, N, N, N};
    tbl[1]  = '{32'h402081B3, N, 0, 4, 4'h1, N, Y, N, N, N, N, N, N};
    tbl[2]  = '{32'h0020F1B3, N, 0, 4, 4'h2, N, Y, N, N, N, N, N, N};
    tbl[3]  = '{32'h4000C093, N, 0, 4, 4'h4, Y, Y, N, N, N, N, N, N};
    tbl[4]  = '{32'h0000A183, N, 2, 7, 4'h0, Y, Y, Y, Y, N, N, N, N};
    tbl[5]  = '{32'h0000A183, Y, 0, 5, 4'h0, Y, Y, Y, Y, N, N, N, N};
    tbl[6]  = '{32'h0020A023, N, 0, 4, 4'h0, Y, N, N, N, Y, N, N, N};
    tbl[7]  = '{32'h0020A023, N, 3, 7, 4'h0, Y, N, N, N, Y, N, N, N};
    tbl[8]  = '{32'h00208463, Y, 0, 3, 4'h1, N, N, N, N, N, Y, N, N};
    tbl[9]  = '{32'h00208463, N, 0, 3, 4'h1, N, N, N, N, N, N, N, N};
    tbl[10] = '{32'h00209463, Y, 0, 3, 4'h1, N, N, N, N, N, N, N, N};
    tbl[11] = '{32'h00209463, N, 0, 3, 4'h1, N, N, N, N, N, Y, N, N};
    tbl[12] = '{32'h00000000, N, 0, 0, 4'h0, N, N, N, N, N, N, Y, Y};
    tbl[13] = '{32'hFFFFFFFF, N, 0, 0, 4'h0, N, N, N, N, N, N, N, Y};
    tbl[14] = '{32'h0000007F, N, 0, 0, 4'h0, N, N, N, N, N, N, N, Y};
    tbl[15] = '{32'h4020D1B3, N, 0, 4, 4'h6, N, Y, N, N, N, N, N, N};

    reset_dut();

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      run   = 1'b0;
      instr = $urandom;
      #1;
      chk($sformatf("idle run=0 cyc%0d", k), 32'(observed()), 32'h0);
    end

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      c = $urandom_range(0, 11);
      case (c)
        0, 1:    r[6:0] = 7'b0110011;
        2, 3:    r[6:0] = 7'b0010011;
        4, 5:    r[6:0] = 7'b0000011;
        6, 7:    r[6:0] = 7'b0100011;
        8, 9:    begin r[6:0] = 7'b1100011; r[14:13] = 2'b00; end
        10:      r[6:0] = 7'b1111111;
        default: r[6:0] = 7'($urandom);
      endcase
      run_vec(model(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    reset_dut();
    for (int n = 0; n < 17; n++) run_vec(model(32'h002081B3, N, 0), $sformatf("wrap%0d", n));
    chk("count after wrap", 32'(instr_count), 32'd1);

    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      instr    = (k == 1) ? 32'h0000A183 : $urandom;
      run      = (k == 1);
      mem_wait = 1'b0;
      zero     = 1'b0;
      #1;
    end
    chk("load WB RegWrite", 32'(RegWrite), 32'd1);
    reset = 1'b0;
    #1;
    chk("async reset RegWrite", 32'(RegWrite), 32'd0);
    chk("async reset pc_we", 32'(pc_we), 32'd0);
    chk("async reset count", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    run       = 1'b0;
    cnt_model = 0;
    run_vec(model(32'h002081B3, N, 0), "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
